isp_ccm_cfg_ctrl: RTL and testbench

Frame-synchronous configuration controller for the colour-correction-matrix stage.
- Accepts coefficient writes from the register bus into a shadow bank at any time.
- Transfers the shadow bank (or an identity matrix in bypass) to the active bank only at a frame boundary, so the CCM never changes coefficients mid-frame.
- Sits between the register-bus decoder and the CCM datapath; drives its nine coefficient inputs directly.

---
 rtl/isp_ccm_cfg_ctrl_pkg.sv | 31 +++
 rtl/isp_vsync_edge.sv | 31 +++
 rtl/isp_ccm_cfg_ctrl.sv | 127 ++++++++++++
 tb/tb_isp_ccm_cfg_ctrl.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_ccm_cfg_ctrl_pkg.sv
// Shared definitions for the CCM configuration controller: coefficient
// indices, identity-matrix default and the apply-sequencer state encoding.
package isp_ccm_cfg_ctrl_pkg;

    localparam int CCM_RR = 0;
    localparam int CCM_RG = 1;
    localparam int CCM_RB = 2;
    localparam int CCM_GR = 3;
    localparam int CCM_GG = 4;
    localparam int CCM_GB = 5;
    localparam int CCM_BR = 6;
    localparam int CCM_BG = 7;
    localparam int CCM_BB = 8;

    localparam int CCM_NUM_COEF = 9;

    // 1.0 under the datapath's >>>10 normalisation
    localparam logic [15:0] CCM_UNITY_DEFAULT = 16'h0400;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } ccm_state_e;

    // True for the diagonal entries of the matrix
    function automatic logic is_diag(input int idx);
        return (idx == CCM_RR) || (idx == CCM_GG) || (idx == CCM_BB);
    endfunction

endpackage

// File: rtl/isp_vsync_edge.sv
// Frame-sync front end: registers vsync, flags its rising edge and counts
// frames. Reusable by any frame-synchronous configuration block.
module isp_vsync_edge #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vsync,
    output logic             vs_rise,
    output logic [CNT_W-1:0] frame_cnt
);

    logic vsync_d;

    // Rising edge is combinational on the current input versus last cycle
    assign vs_rise = vsync & ~vsync_d;

    // Delay register and wrapping frame counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vsync_d   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            vsync_d <= vsync;
            if (vs_rise) begin
                frame_cnt <= frame_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/isp_ccm_cfg_ctrl.sv
// CCM configuration controller. Register-bus writes land in a shadow bank;
// a commit arms a transfer that happens only in the cycle after a frame
// start, so the CCM coefficients never change mid-frame.
// Handshake: cfg_commit is a single-cycle request with no ready; it is
// accepted in IDLE or in the APPLY cycle and ignored while already pending.
module isp_ccm_cfg_ctrl
    import isp_ccm_cfg_ctrl_pkg::*;
#(
    parameter int                 COEF_W = 16,
    parameter logic [COEF_W-1:0]  UNITY  = COEF_W'(CCM_UNITY_DEFAULT),
    parameter int                 CNT_W  = 16
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic              cfg_wr_en,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_wdata,
    input  logic              cfg_commit,
    input  logic              cfg_bypass,
    input  logic              in_vsync,
    output logic [COEF_W-1:0] m_rr,
    output logic [COEF_W-1:0] m_rg,
    output logic [COEF_W-1:0] m_rb,
    output logic [COEF_W-1:0] m_gr,
    output logic [COEF_W-1:0] m_gg,
    output logic [COEF_W-1:0] m_gb,
    output logic [COEF_W-1:0] m_br,
    output logic [COEF_W-1:0] m_bg,
    output logic [COEF_W-1:0] m_bb,
    output logic              cfg_pending,
    output logic              cfg_done,
    output logic              cfg_addr_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    ccm_state_e        state;
    logic              vs_rise;
    logic              addr_ok;
    logic [COEF_W-1:0] shadow [CCM_NUM_COEF];
    logic [COEF_W-1:0] active [CCM_NUM_COEF];

    function automatic logic [COEF_W-1:0] ident_coef(input int idx);
        return is_diag(idx) ? UNITY : '0;
    endfunction

    isp_vsync_edge #(
        .CNT_W (CNT_W)
    ) u_vsync_edge (
        .clk       (pclk),
        .rst_n     (rst_n),
        .vsync     (in_vsync),
        .vs_rise   (vs_rise),
        .frame_cnt (frame_cnt)
    );

    assign addr_ok = (cfg_addr < 4'(CCM_NUM_COEF));

    // Shadow bank: bus writes at any time, last write wins; bad index flagged
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            for (int i = 0; i < CCM_NUM_COEF; i++) begin
                shadow[i] <= ident_coef(i);
            end
            cfg_addr_err <= 1'b0;
        end else begin
            if (cfg_wr_en && addr_ok) begin
                shadow[cfg_addr] <= cfg_wdata;
            end
            cfg_addr_err <= cfg_wr_en && !addr_ok;
        end
    end

    // Apply sequencer: arm on commit, wait for frame start, copy in one cycle
    always_ff @(posedge pclk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cfg_pending <= 1'b0;
            cfg_done    <= 1'b0;
            for (int i = 0; i < CCM_NUM_COEF; i++) begin
                active[i] <= ident_coef(i);
            end
        end else begin
            cfg_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (cfg_commit) begin
                        state       <= ST_PENDING;
                        cfg_pending <= 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (vs_rise) begin
                        state    <= ST_APPLY;
                        cfg_done <= 1'b1;
                    end
                end
                ST_APPLY: begin
                    // Copies the pre-edge shadow, so a write in this cycle waits
                    for (int i = 0; i < CCM_NUM_COEF; i++) begin
                        active[i] <= cfg_bypass ? ident_coef(i) : shadow[i];
                    end
                    if (cfg_commit) begin
                        state <= ST_PENDING;
                    end else begin
                        state       <= ST_IDLE;
                        cfg_pending <= 1'b0;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    cfg_pending <= 1'b0;
                end
            endcase
        end
    end

    assign m_rr = active[CCM_RR];
    assign m_rg = active[CCM_RG];
    assign m_rb = active[CCM_RB];
    assign m_gr = active[CCM_GR];
    assign m_gg = active[CCM_GG];
    assign m_gb = active[CCM_GB];
    assign m_br = active[CCM_BR];
    assign m_bg = active[CCM_BG];
    assign m_bb = active[CCM_BB];

endmodule

// File: tb/tb_isp_ccm_cfg_ctrl.sv
// Bench for isp_ccm_cfg_ctrl: directed stimulus, a frame-level reference
// model compared every cycle, and literal spot checks. The frame counter is
// narrowed to 8 bits so its wrap is reachable in a short run.
module tb_isp_ccm_cfg_ctrl;

  localparam int CW = 8;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        cfg_wr_en;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_commit;
  logic        cfg_bypass;
  logic        in_vsync;
  logic [15:0] m_rr, m_rg, m_rb, m_gr, m_gg, m_gb, m_br, m_bg, m_bb;
  logic        cfg_pending, cfg_done, cfg_addr_err;
  logic [CW-1:0] frame_cnt;

  int total = 0;
  int bad   = 0;

  always #5 pclk = ~pclk;

  isp_ccm_cfg_ctrl #(.COEF_W(16), .UNITY(16'h0400), .CNT_W(CW)) dut (
    .pclk(pclk), .rst_n(rst_n), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_bypass(cfg_bypass),
    .in_vsync(in_vsync),
    .m_rr(m_rr), .m_rg(m_rg), .m_rb(m_rb), .m_gr(m_gr), .m_gg(m_gg),
    .m_gb(m_gb), .m_br(m_br), .m_bg(m_bg), .m_bb(m_bb),
    .cfg_pending(cfg_pending), .cfg_done(cfg_done),
    .cfg_addr_err(cfg_addr_err), .frame_cnt(frame_cnt)
  );

  logic [15:0] dut_m [9];
  always_comb begin
    dut_m[0] = m_rr; dut_m[1] = m_rg; dut_m[2] = m_rb;
    dut_m[3] = m_gr; dut_m[4] = m_gg; dut_m[5] = m_gb;
    dut_m[6] = m_br; dut_m[7] = m_bg; dut_m[8] = m_bb;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame-level view) ----------------
  function automatic logic [15:0] ident(input int i);
    return (i == 0 || i == 4 || i == 8) ? 16'h0400 : 16'h0000;
  endfunction

  logic [15:0]   md_shadow [9];
  logic [15:0]   md_active [9];
  bit            md_valid = 0;
  bit            md_waiting;   // request accepted, frame start not yet seen
  bit            md_apply;     // this cycle is the copy cycle
  bit            md_err;
  bit            md_vs_prev;
  logic [CW-1:0] md_fcnt;

  always @(posedge pclk) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) begin
        md_shadow[i] = ident(i);
        md_active[i] = ident(i);
      end
      md_waiting = 0; md_apply = 0; md_err = 0; md_vs_prev = 0; md_fcnt = '0;
      md_valid = 1;
    end else begin
      bit rise;
      bit was_apply;
      rise = in_vsync && !md_vs_prev;
      md_vs_prev = in_vsync;
      was_apply = md_apply;
      if (was_apply)
        for (int i = 0; i < 9; i++) md_active[i] = cfg_bypass ? ident(i) : md_shadow[i];
      if (cfg_wr_en && cfg_addr <= 4'd8) md_shadow[cfg_addr] = cfg_wdata;
      md_err = cfg_wr_en && cfg_addr > 4'd8;
      md_apply = md_waiting && rise;
      if (was_apply)                 md_waiting = cfg_commit;
      else if (md_waiting && rise)   md_waiting = 0;
      else if (cfg_commit)           md_waiting = 1;
      if (rise) md_fcnt = md_fcnt + 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge pclk) begin
    if (md_valid) begin
      for (int i = 0; i < 9; i++) check($sformatf("m[%0d]", i), {16'h0, dut_m[i]}, {16'h0, md_active[i]});
      check("cfg_pending", {31'h0, cfg_pending}, {31'h0, md_waiting || md_apply});
      check("cfg_done", {31'h0, cfg_done}, {31'h0, md_apply});
      check("cfg_addr_err", {31'h0, cfg_addr_err}, {31'h0, md_err});
      check("frame_cnt", 32'(frame_cnt), 32'(md_fcnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    cfg_wr_en = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr_en = 0;
  endtask

  task automatic commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
  endtask

  task automatic vsync_pulse();
    in_vsync = 1;
    tick();
    tick();
    in_vsync = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 0; cfg_wr_en = 0; cfg_addr = 0; cfg_wdata = 0;
    cfg_commit = 0; cfg_bypass = 0; in_vsync = 0;

    // reset
    tick(); tick();
    @(negedge pclk);
    check("rst m_rr", 32'(m_rr), 32'h0400);
    check("rst m_gg", 32'(m_gg), 32'h0400);
    check("rst m_bb", 32'(m_bb), 32'h0400);
    check("rst m_rg", 32'(m_rg), 32'h0);
    check("rst pending", 32'(cfg_pending), 32'h0);
    check("rst frame_cnt", 32'(frame_cnt), 32'h0);
    rst_n = 1;
    tick();

    // basic apply: rise in cycle T
    write(4'd0, 16'h0500);
    write(4'd4, 16'hFF00);
    commit();
    in_vsync = 1;
    @(negedge pclk);
    check("T done", 32'(cfg_done), 32'h0);
    check("T m_rr", 32'(m_rr), 32'h0400);
    tick();
    @(negedge pclk);
    check("T+1 done", 32'(cfg_done), 32'h1);
    check("T+1 m_rr", 32'(m_rr), 32'h0400);
    check("T+1 pending", 32'(cfg_pending), 32'h1);
    tick();
    in_vsync = 0;
    @(negedge pclk);
    check("T+2 m_rr", 32'(m_rr), 32'h0500);
    check("T+2 m_gg", 32'(m_gg), 32'hFF00);
    check("T+2 done", 32'(cfg_done), 32'h0);
    check("T+2 pending", 32'(cfg_pending), 32'h0);
    tick();

    // bypass loads identity, shadow is kept
    write(4'd8, 16'h0200);
    cfg_bypass = 1;
    commit();
    vsync_pulse();
    @(negedge pclk);
    check("byp m_rr", 32'(m_rr), 32'h0400);
    check("byp m_bb", 32'(m_bb), 32'h0400);
    cfg_bypass = 0;
    tick();
    commit();
    vsync_pulse();
    @(negedge pclk);
    check("nobyp m_rr", 32'(m_rr), 32'h0500);
    check("nobyp m_bb", 32'(m_bb), 32'h0200);
    tick();

    // write and commit inside the apply cycle
    commit();
    in_vsync = 1;
    tick();
    cfg_wr_en = 1; cfg_addr = 4'd2; cfg_wdata = 16'h0777; cfg_commit = 1;
    @(negedge pclk);
    check("apply-cyc done", 32'(cfg_done), 32'h1);
    tick();
    cfg_wr_en = 0; cfg_commit = 0; in_vsync = 0;
    @(negedge pclk);
    check("late wr m_rb", 32'(m_rb), 32'h0);
    check("late commit pending", 32'(cfg_pending), 32'h1);
    tick();
    vsync_pulse();
    @(negedge pclk);
    check("next frame m_rb", 32'(m_rb), 32'h0777);
    check("next frame pending", 32'(cfg_pending), 32'h0);
    tick();

    // commit coincident with rise in IDLE applies one frame later
    write(4'd3, 16'h0ABC);
    cfg_commit = 1; in_vsync = 1;
    tick();
    cfg_commit = 0;
    tick();
    @(negedge pclk);
    check("coinc pending", 32'(cfg_pending), 32'h1);
    check("coinc m_gr", 32'(m_gr), 32'h0);
    in_vsync = 0;
    tick();
    vsync_pulse();
    @(negedge pclk);
    check("coinc later m_gr", 32'(m_gr), 32'h0ABC);
    tick();

    // invalid address
    write(4'd12, 16'h1234);
    @(negedge pclk);
    check("addr_err pulse", 32'(cfg_addr_err), 32'h1);
    tick();
    @(negedge pclk);
    check("addr_err clear", 32'(cfg_addr_err), 32'h0);
    tick();

    // reset while pending drops the request
    write(4'd1, 16'h0111);
    commit();
    rst_n = 0;
    tick();
    rst_n = 1;
    vsync_pulse();
    @(negedge pclk);
    check("rst-pend m_rr", 32'(m_rr), 32'h0400);
    check("rst-pend m_rg", 32'(m_rg), 32'h0);
    check("rst-pend pending", 32'(cfg_pending), 32'h0);
    tick();

    // frame counter wrap
    for (int k = 0; k < 700; k++) begin
      in_vsync = ~in_vsync;
      tick();
      if (md_fcnt == 8'hFF) break;
    end
    @(negedge pclk);
    check("fcnt max", 32'(frame_cnt), 32'hFF);
    if (in_vsync) begin
      in_vsync = 0;
      tick();
    end
    in_vsync = 1;
    tick();
    @(negedge pclk);
    check("fcnt wrap", 32'(frame_cnt), 32'h0);
    in_vsync = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
